// File: rtl/amp_cfg_pkg.sv
// -----------------------------------------------------------------------------
// amp_cfg_pkg
// Shared types and constants for the amplifier configuration scheduler:
//   - state_t      : scheduler FSM state encoding
//   - src_t        : which requester owns the current write command
//   - boot_entry_t : one boot table entry (register address + data byte)
//   - DEF_VOL_REG / DEF_MUTE_REG : default amp register addresses
// -----------------------------------------------------------------------------
package amp_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PWR_WAIT,
        ST_ISSUE,
        ST_WAIT,
        ST_READY,
        ST_FAULT
    } state_t;

    typedef enum logic [1:0] {
        SRC_BOOT,
        SRC_MUTE,
        SRC_VOL
    } src_t;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } boot_entry_t;

    localparam logic [7:0] DEF_VOL_REG  = 8'h40;
    localparam logic [7:0] DEF_MUTE_REG = 8'h0C;

endpackage

// File: rtl/amp_cfg_scheduler_boot_rom.sv
// -----------------------------------------------------------------------------
// amp_boot_rom
// Combinational 8-entry boot configuration table for the amplifier.
// Ports:
//   boot_idx  in  3  table index
//   rom_reg   out 8  register address of the selected entry
//   rom_data  out 8  data byte of the selected entry
// Unused entries read as 0/0.
// -----------------------------------------------------------------------------
module amp_boot_rom
    import amp_cfg_pkg::*;
(
    input  logic [2:0] boot_idx,
    output logic [7:0] rom_reg,
    output logic [7:0] rom_data
);

    boot_entry_t entry;

    // NOTE: every signal written in always_comb gets a default first so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        entry = '{reg_addr: 8'h00, data: 8'h00};
        case (boot_idx)
            3'd0: entry = '{reg_addr: 8'h40, data: 8'h18};
            3'd1: entry = '{reg_addr: 8'd53, data: 8'h08};
            3'd2: entry = '{reg_addr: 8'h0C, data: 8'h00};
            3'd3: entry = '{reg_addr: 8'h01, data: 8'h00};
            default: ;
        endcase
    end

    assign rom_reg  = entry.reg_addr;
    assign rom_data = entry.data;

endmodule

// File: rtl/amp_cfg_scheduler.sv
// -----------------------------------------------------------------------------
// amp_cfg_scheduler
// Powers up the amplifier, replays the boot table through a shared byte-write
// I2C engine, then serves mute and volume writes (mute has priority). NACKed
// writes are retried up to MAX_RETRY times; exhaustion latches a fault that
// only reset clears.
// Ports:
//   clk, resetb        clock, synchronous active-low reset
//   start              rising edge in IDLE begins power-up
//   mute               level; every change schedules a MUTE_REG write
//   vol_req, vol_val   one-cycle request carrying a new volume code
//   wr_valid/wr_ready  command handshake towards the write engine
//   wr_reg, wr_data    command payload, stable while wr_valid=1
//   wr_done, wr_nack   transfer completion and its NACK status
//   amp_en             amplifier power enable
//   cfg_ready          boot table complete, runtime writes are served
//   fault              sticky retry-exhausted flag
// All outputs are registered.
// -----------------------------------------------------------------------------
module amp_cfg_scheduler
    import amp_cfg_pkg::*;
#(
    parameter logic [15:0] PWR_DLY   = 16'd1000,
    parameter int          BOOT_LEN  = 4,
    parameter int          MAX_RETRY = 2,
    parameter logic [7:0]  VOL_REG   = DEF_VOL_REG,
    parameter logic [7:0]  MUTE_REG  = DEF_MUTE_REG
)(
    input  logic       clk,
    input  logic       resetb,
    input  logic       start,
    input  logic       mute,
    input  logic       vol_req,
    input  logic [7:0] vol_val,
    output logic       wr_valid,
    input  logic       wr_ready,
    output logic [7:0] wr_reg,
    output logic [7:0] wr_data,
    input  logic       wr_done,
    input  logic       wr_nack,
    output logic       amp_en,
    output logic       cfg_ready,
    output logic       fault
);

    state_t      state, state_nx;
    src_t        src, src_nx;
    logic [15:0] cnt, cnt_nx;
    logic [2:0]  boot_idx, boot_idx_nx;
    logic [1:0]  retry, retry_nx;
    logic        load_cmd;
    logic [7:0]  cmd_reg, cmd_data;
    logic [7:0]  rom_reg, rom_data;

    logic        start_q, mute_q;
    logic        mute_pend, vol_pend;
    logic [7:0]  vol_pend_val;
    logic        accept;

    assign accept = (state == ST_ISSUE) && wr_ready;

    // The ROM is addressed by the next index so the entry is ready on the
    // same edge that enters ISSUE.
    amp_boot_rom u_boot_rom (
        .boot_idx (boot_idx_nx),
        .rom_reg  (rom_reg),
        .rom_data (rom_data)
    );

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic. load_cmd marks the edges that enter ISSUE with a new
    // command; a retry re-enters ISSUE without reloading, so the payload is
    // the identical command.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nx    = state;
        src_nx      = src;
        cnt_nx      = cnt;
        boot_idx_nx = boot_idx;
        retry_nx    = retry;
        load_cmd    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start && !start_q) begin
                    state_nx = ST_PWR_WAIT;
                    cnt_nx   = PWR_DLY - 16'd1;
                end
            end

            ST_PWR_WAIT: begin
                if (cnt == 16'd0) begin
                    state_nx    = ST_ISSUE;
                    src_nx      = SRC_BOOT;
                    boot_idx_nx = 3'd0;
                    load_cmd    = 1'b1;
                end else begin
                    cnt_nx = cnt - 16'd1;
                end
            end

            ST_ISSUE: begin
                if (accept) begin
                    state_nx = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (wr_done) begin
                    if (!wr_nack) begin
                        retry_nx = 2'd0;
                        if (src == SRC_BOOT && boot_idx != 3'(BOOT_LEN - 1)) begin
                            boot_idx_nx = boot_idx + 3'd1;
                            state_nx    = ST_ISSUE;
                            load_cmd    = 1'b1;
                        end else begin
                            state_nx = ST_READY;
                        end
                    end else if (retry < 2'(MAX_RETRY)) begin
                        retry_nx = retry + 2'd1;
                        state_nx = ST_ISSUE;
                    end else begin
                        state_nx = ST_FAULT;
                    end
                end
            end

            ST_READY: begin
                if (mute_pend) begin
                    src_nx   = SRC_MUTE;
                    state_nx = ST_ISSUE;
                    load_cmd = 1'b1;
                end else if (vol_pend) begin
                    src_nx   = SRC_VOL;
                    state_nx = ST_ISSUE;
                    load_cmd = 1'b1;
                end
            end

            ST_FAULT: ;

            default: state_nx = ST_IDLE;
        endcase
    end

    // Payload for a newly loaded command.
    always_comb begin
        cmd_reg  = rom_reg;
        cmd_data = rom_data;
        case (src_nx)
            SRC_MUTE: begin
                cmd_reg  = MUTE_REG;
                cmd_data = {7'b0, mute_q};
            end
            SRC_VOL: begin
                cmd_reg  = VOL_REG;
                cmd_data = vol_pend_val;
            end
            default: ;
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath, request capture and registered outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!resetb) begin
            src          <= SRC_BOOT;
            cnt          <= 16'd0;
            boot_idx     <= 3'd0;
            retry        <= 2'd0;
            start_q      <= 1'b0;
            mute_q       <= 1'b0;
            mute_pend    <= 1'b0;
            vol_pend     <= 1'b0;
            vol_pend_val <= 8'h00;
            wr_valid     <= 1'b0;
            wr_reg       <= 8'h00;
            wr_data      <= 8'h00;
            amp_en       <= 1'b0;
            cfg_ready    <= 1'b0;
            fault        <= 1'b0;
        end else begin
            src      <= src_nx;
            cnt      <= cnt_nx;
            boot_idx <= boot_idx_nx;
            retry    <= retry_nx;
            start_q  <= start;
            mute_q   <= mute;

            // A mute change during a mute transfer re-arms the flag; the set
            // wins over the clear on the accept edge.
            if (state != ST_FAULT && mute != mute_q) begin
                mute_pend <= 1'b1;
            end else if (accept && src == SRC_MUTE) begin
                mute_pend <= 1'b0;
            end

            // Volume requests coalesce: only the latest value is kept, and it
            // is consumed when copied into the command payload.
            if (state != ST_FAULT && vol_req) begin
                vol_pend     <= 1'b1;
                vol_pend_val <= vol_val;
            end else if (load_cmd && src_nx == SRC_VOL) begin
                vol_pend <= 1'b0;
            end

            if (load_cmd) begin
                wr_reg  <= cmd_reg;
                wr_data <= cmd_data;
            end

            // Outputs follow the next state so they are registered yet line
            // up with the state they describe.
            wr_valid  <= (state_nx == ST_ISSUE);
            amp_en    <= !(state_nx inside {ST_IDLE, ST_FAULT});
            fault     <= (state_nx == ST_FAULT);
            cfg_ready <= (state_nx != ST_FAULT) && (cfg_ready || state_nx == ST_READY);
        end
    end

endmodule

// File: tb/tb_amp_cfg_scheduler.sv
// -----------------------------------------------------------------------------
// tb_amp_cfg_scheduler
// Directed bench for amp_cfg_scheduler with PWR_DLY=10, BOOT_LEN=4,
// MAX_RETRY=2. The bench plays the write engine; inputs change and outputs
// are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_amp_cfg_scheduler;

    localparam logic [7:0] VOL_REG  = 8'h40;
    localparam logic [7:0] MUTE_REG = 8'h0C;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic       start = 1'b0;
    logic       mute = 1'b0;
    logic       vol_req = 1'b0;
    logic [7:0] vol_val = 8'h00;
    logic       wr_valid;
    logic       wr_ready = 1'b0;
    logic [7:0] wr_reg;
    logic [7:0] wr_data;
    logic       wr_done = 1'b0;
    logic       wr_nack = 1'b0;
    logic       amp_en;
    logic       cfg_ready;
    logic       fault;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] boot_reg [4] = '{8'h40, 8'h35, 8'h0C, 8'h01};
    logic [7:0] boot_dat [4] = '{8'h18, 8'h08, 8'h00, 8'h00};

    always #5 clk = ~clk;

    amp_cfg_scheduler #(
        .PWR_DLY   (16'd10),
        .BOOT_LEN  (4),
        .MAX_RETRY (2),
        .VOL_REG   (VOL_REG),
        .MUTE_REG  (MUTE_REG)
    ) dut (
        .clk       (clk),
        .resetb    (resetb),
        .start     (start),
        .mute      (mute),
        .vol_req   (vol_req),
        .vol_val   (vol_val),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_reg    (wr_reg),
        .wr_data   (wr_data),
        .wr_done   (wr_done),
        .wr_nack   (wr_nack),
        .amp_en    (amp_en),
        .cfg_ready (cfg_ready),
        .fault     (fault)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(tag, {wr_valid, wr_reg, wr_data, amp_en, cfg_ready, fault}, 32'd0);
    endtask

    task automatic apply_reset();
        resetb = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_out");
        resetb = 1'b1;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_vol(input logic [7:0] val);
        vol_req = 1'b1;
        vol_val = val;
        @(negedge clk);
        vol_req = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!wr_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(wr_valid), 32'd1);
    endtask

    // Wait for a command, check its payload, hold off acceptance for 'hold'
    // cycles while checking stability, then accept it.
    task automatic accept_cmd(input string tag, input logic [7:0] r, input logic [7:0] d,
                              input int hold);
        wait_valid(tag);
        check({tag, "_reg"}, 32'(wr_reg), 32'(r));
        check({tag, "_data"}, 32'(wr_data), 32'(d));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold"}, {wr_valid, wr_reg, wr_data}, {1'b1, r, d});
        end
        wr_ready = 1'b1;
        @(negedge clk);
        wr_ready = 1'b0;
        check({tag, "_accepted"}, 32'(wr_valid), 32'd0);
    endtask

    task automatic finish_cmd(input logic nack);
        @(negedge clk);
        wr_done = 1'b1;
        wr_nack = nack;
        @(negedge clk);
        wr_done = 1'b0;
        wr_nack = 1'b0;
    endtask

    task automatic expect_quiet(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            seen = seen | wr_valid;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    task automatic run_boot(input int hold0);
        for (int i = 0; i < 4; i++) begin
            accept_cmd($sformatf("boot%0d", i), boot_reg[i], boot_dat[i], (i == 0) ? hold0 : 0);
            check($sformatf("boot%0d_not_ready", i), 32'(cfg_ready), 32'd0);
            finish_cmd(1'b0);
        end
        check("boot_cfg_ready", 32'(cfg_ready), 32'd1);
    endtask

    initial begin
        int n;

        // Reset, power-up delay, boot replay with backpressure on entry 0.
        @(negedge clk);
        apply_reset();
        pulse_start();
        check("amp_en_rise", {amp_en, wr_valid}, 32'b10);
        n = 0;
        while (!wr_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("pwr_dly_cycles", 32'(n), 32'd10);
        run_boot(7);
        check("amp_en_ready", {amp_en, fault}, 32'b10);

        // Mute change and vol_req together: mute served first.
        mute    = 1'b1;
        vol_req = 1'b1;
        vol_val = 8'h22;
        @(negedge clk);
        vol_req = 1'b0;
        accept_cmd("prio_mute", MUTE_REG, 8'h01, 0);
        finish_cmd(1'b0);
        accept_cmd("prio_vol", VOL_REG, 8'h22, 0);
        finish_cmd(1'b0);
        expect_quiet("prio_quiet", 8);

        // Three volume requests during a mute transfer coalesce into one.
        mute = 1'b0;
        accept_cmd("coal_mute", MUTE_REG, 8'h00, 0);
        pulse_vol(8'h10);
        pulse_vol(8'h20);
        pulse_vol(8'h30);
        finish_cmd(1'b0);
        accept_cmd("coal_vol", VOL_REG, 8'h30, 0);
        finish_cmd(1'b0);
        expect_quiet("coal_quiet", 10);

        // Two NACKs then ACK: three identical attempts, no fault.
        pulse_vol(8'h55);
        for (int i = 0; i < 3; i++) begin
            accept_cmd($sformatf("retry%0d", i), VOL_REG, 8'h55, 0);
            finish_cmd(i < 2);
        end
        check("retry_ok", {fault, amp_en, cfg_ready}, 32'b011);

        // Three NACKs: fault latches, amp off, further requests ignored.
        pulse_vol(8'h66);
        for (int i = 0; i < 3; i++) begin
            accept_cmd($sformatf("nack%0d", i), VOL_REG, 8'h66, 0);
            finish_cmd(1'b1);
        end
        check("fault_out", {fault, amp_en, cfg_ready, wr_valid}, 32'b1000);
        pulse_vol(8'h77);
        expect_quiet("fault_quiet", 20);
        check("fault_sticky", 32'(fault), 32'd1);

        // Reset while waiting on boot entry 2, then full replay from entry 0.
        apply_reset();
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            accept_cmd($sformatf("rb%0d", i), boot_reg[i], boot_dat[i], 0);
            finish_cmd(1'b0);
        end
        accept_cmd("rb2", boot_reg[2], boot_dat[2], 0);
        resetb = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset_out");
        resetb = 1'b1;
        @(negedge clk);
        pulse_start();
        run_boot(0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
